if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch front end and the write-side producer of the instruction queue.
- Holds the fetch PC and issues one-at-a-time word fetches to the memory controller.
- Applies a static branch prediction to each returned word and pushes the instruction, PC and prediction bit into the queue.
- Obeys queue back-pressure; on a pipeline flush (clear) it discards in-flight work and restarts at a redirect PC.

Parameters:
- RESET_PC, 32'h00000000, fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low all state and outputs hold
- clear  in  1  flush/redirect request from commit
- redirect_pc_i  in  32  new fetch PC, valid with clear
- mem_req_o  out  1  fetch request to memory controller
- mem_addr_o  out  32  fetch address
- mem_valid_i  in  1  one-cycle pulse: mem_inst_i valid, request complete
- mem_inst_i  in  32  fetched word
- full_i  in  1  queue full flag (queue reserves 2-slot margin)
- we_o  out  1  queue write strobe
- inst_o  out  32  instruction to queue
- pc_o  out  32  its PC
- bp_o  out  1  predicted taken

Behaviour:
- All outputs are registered. Every update is gated by rdy, except rst.
- Reset: state=IDLE, pc=RESET_PC, mem_req_o=0, mem_addr_o=RESET_PC, we_o=0, inst_o=0, pc_o=0, bp_o=0.
- States: IDLE, WAIT, HOLD, DISCARD.
- IDLE → WAIT next rdy edge; mem_req_o<=1, mem_addr_o<=pc.
- Memory protocol:
  - mem_req_o and mem_addr_o stay stable until a cycle with mem_valid_i=1.
  - A new request (new address) may be presented in the very next cycle (back-to-back).
  - Only one request is outstanding at a time.
- WAIT, mem_valid_i=1, full_i=0, clear=0:
  - we_o<=1, inst_o<=mem_inst_i, pc_o<=pc, bp_o<=pred.
  - pc<=next; mem_addr_o<=next; stay in WAIT (mem_req_o stays 1).
  - Steady-state throughput is 1 instruction per memory response.
- WAIT, mem_valid_i=1, full_i=1:
  - Latch word/pc/pred into the hold buffer; mem_req_o<=0; we_o<=0; → HOLD.
- HOLD, full_i=0: push the buffered entry (we_o<=1), pc<=next, mem_req_o<=1 at next, → WAIT.
- we_o is a single-cycle pulse and is 0 in every cycle not listed above.
- full_i is sampled at the push edge. The queue's 2-slot margin absorbs the one-cycle strobe lag.
- Prediction (pc = PC of fetched word, imm sign-extended, arithmetic mod 2^32):
  - opcode 1101111 (JAL): pred=1, next=pc+J-imm.
  - opcode 1100011 (branch): pred=imm[12], next = imm[12] ? pc+B-imm : pc+4 (backward taken).
  - All others including JALR: pred=0, next=pc+4.
- clear has priority over all but rst; we_o<=0 at that edge; pc<=redirect_pc_i.
  - clear in IDLE/HOLD: hold buffer dropped; mem_req_o<=1, mem_addr_o<=redirect_pc_i; → WAIT.
  - clear in WAIT with mem_valid_i=0: request cannot be aborted; address held; → DISCARD.
  - clear in WAIT with mem_valid_i=1: response dropped; new request at redirect_pc_i next cycle; stay in WAIT.
  - DISCARD: on mem_valid_i, drop the word, mem_addr_o<=pc, → WAIT. A second clear in DISCARD only updates pc.
- rst mid-request: returns to IDLE. A later stale mem_valid_i in IDLE is ignored.
- rdy low: no state change; mem_valid_i arriving while rdy=0 is not captured (the controller holds under rdy too).

Test Plan:
- Reset with RESET_PC=0; memory returns addi words with 1-cycle latency → mem_addr_o 0,4,8; we_o pulses with pc_o=0,4,8; bp_o=0.
- Word at 0x10 is JAL imm=+0x20 → pc_o=0x10, bp_o=1; next mem_addr_o=0x30.
- BEQ at 0x40 with imm=-8 → bp_o=1, next addr 0x38. BEQ with imm=+8 → bp_o=0, next addr 0x44.
- full_i=1 at response of addr 0x8 → mem_req_o=0, no we_o. full_i drops 3 cycles later → single we_o with pc_o=0x8, then request 0xC.
- clear with redirect 0x100 while request for 0x20 outstanding (response 2 cycles later) → mem_addr_o holds 0x20, response not pushed, next request 0x100, first we_o has pc_o=0x100.
- clear coincident with mem_valid_i → no we_o, next cycle mem_addr_o=redirect_pc_i; rdy=0 for 4 cycles mid-stream → outputs frozen, sequence resumes unchanged.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: one outstanding word fetch, static prediction, push into the instruction queue.
// Latency: a returned word is pushed on the edge that sees mem_valid_i; the next request goes out on that same edge.
// Backpressure: full_i parks the returned word in a one-entry hold buffer and drops mem_req_o until the queue drains.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_inst_i,
    input  logic        full_i,
    output logic        we_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        bp_o
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DISCARD} state_t;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] hold_inst, hold_inst_n;
    logic        req_n, we_n, bp_n;
    logic [31:0] addr_n, inst_n, pco_n;

    logic [31:0] src_inst, imm_j, imm_b, next_pc;
    logic        pred;

    // The word being predicted is either the live response or the parked one; pc always names it.
    always_comb begin
        src_inst = (state == HOLD) ? hold_inst : mem_inst_i;
        imm_j    = {{12{src_inst[31]}}, src_inst[19:12], src_inst[20], src_inst[30:21], 1'b0};
        imm_b    = {{20{src_inst[31]}}, src_inst[7], src_inst[30:25], src_inst[11:8], 1'b0};
        pred     = 1'b0;
        next_pc  = pc + 32'd4;
        case (src_inst[6:0])
            OP_JAL: begin
                pred    = 1'b1;
                next_pc = pc + imm_j;
            end
            OP_BRANCH: begin
                if (src_inst[31]) begin
                    pred    = 1'b1;
                    next_pc = pc + imm_b;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        hold_inst_n = hold_inst;
        req_n       = mem_req_o;
        addr_n      = mem_addr_o;
        we_n        = 1'b0;
        inst_n      = inst_o;
        pco_n       = pc_o;
        bp_n        = bp_o;
        case (state)
            IDLE: begin
                req_n   = 1'b1;
                addr_n  = clear ? redirect_pc_i : pc;
                pc_n    = clear ? redirect_pc_i : pc;
                state_n = WAIT;
            end
            WAIT: begin
                if (clear) begin
                    pc_n = redirect_pc_i;
                    // A request already on the bus cannot be withdrawn; wait it out in DISCARD.
                    if (mem_valid_i) addr_n = redirect_pc_i;
                    else             state_n = DISCARD;
                end else if (mem_valid_i) begin
                    if (!full_i) begin
                        we_n   = 1'b1;
                        inst_n = mem_inst_i;
                        pco_n  = pc;
                        bp_n   = pred;
                        pc_n   = next_pc;
                        addr_n = next_pc;
                    end else begin
                        hold_inst_n = mem_inst_i;
                        req_n       = 1'b0;
                        state_n     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (clear) begin
                    pc_n    = redirect_pc_i;
                    req_n   = 1'b1;
                    addr_n  = redirect_pc_i;
                    state_n = WAIT;
                end else if (!full_i) begin
                    we_n    = 1'b1;
                    inst_n  = hold_inst;
                    pco_n   = pc;
                    bp_n    = pred;
                    pc_n    = next_pc;
                    req_n   = 1'b1;
                    addr_n  = next_pc;
                    state_n = WAIT;
                end
            end
            DISCARD: begin
                if (clear) pc_n = redirect_pc_i;
                if (mem_valid_i) begin
                    addr_n  = clear ? redirect_pc_i : pc;
                    state_n = WAIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            hold_inst  <= 32'd0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= RESET_PC;
            we_o       <= 1'b0;
            inst_o     <= 32'd0;
            pc_o       <= 32'd0;
            bp_o       <= 1'b0;
        end else if (rdy) begin
            state      <= state_n;
            pc         <= pc_n;
            hold_inst  <= hold_inst_n;
            mem_req_o  <= req_n;
            mem_addr_o <= addr_n;
            we_o       <= we_n;
            inst_o     <= inst_n;
            pc_o       <= pco_n;
            bp_o       <= bp_n;
        end
    end

endmodule
